// File: rtl/rom_arbiter.sv
//==============================================================================
// Module   : rom_arbiter
// Purpose  : Shares one single-port synchronous ROM between the CPU fetch path
//            and an auxiliary reader; one read per clock, one in flight each.
//            Optional macro ROMARB_ROUNDROBIN_EN replaces fixed CPU priority and
//            the aux anti-starvation counter with round-robin on ties.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rom_arbiter #(
    parameter  int KB     = 128,
    parameter  int STARVE = 4,
    localparam int AW     = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_a,
    output logic          cpu_ack,
    output logic [7:0]    cpu_q,
    input  logic          aux_req,
    input  logic [AW-1:0] aux_a,
    output logic          aux_ack,
    output logic [7:0]    aux_q,
    output logic [AW-1:0] rom_a,
    input  logic [7:0]    rom_q
);

    logic r_cpu_pend;
    logic r_aux_pend;
    logic r_s1_vld;
    logic r_s1_id;      // 0 = CPU, 1 = aux
    logic r_s2_vld;
    logic r_s2_id;

    logic w_cpu_elig;
    logic w_aux_elig;
    logic w_grant_cpu;
    logic w_grant_aux;

    assign w_cpu_elig = cpu_req && !r_cpu_pend;
    assign w_aux_elig = aux_req && !r_aux_pend;

`ifdef ROMARB_ROUNDROBIN_EN
    logic r_last_aux;

    // On a tie the requester that did not win last time goes next.
    assign w_grant_aux = w_aux_elig && (!w_cpu_elig || !r_last_aux);
    assign w_grant_cpu = w_cpu_elig && !w_grant_aux;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_aux <= 1'b1;
        end else if (w_grant_cpu || w_grant_aux) begin
            r_last_aux <= w_grant_aux;
        end
    end
`else
    localparam logic [3:0] c_STARVE = 4'(STARVE);

    logic [3:0] r_starve_cnt;

    assign w_grant_aux = w_aux_elig && ((r_starve_cnt == c_STARVE) || !w_cpu_elig);
    assign w_grant_cpu = w_cpu_elig && !w_grant_aux;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!aux_req || w_grant_aux) begin
            r_starve_cnt <= 4'd0;
        end else if (w_aux_elig && (r_starve_cnt != c_STARVE)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rom_a      <= '0;
            cpu_q      <= 8'd0;
            aux_q      <= 8'd0;
            cpu_ack    <= 1'b0;
            aux_ack    <= 1'b0;
            r_cpu_pend <= 1'b0;
            r_aux_pend <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_id    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            aux_ack <= 1'b0;

            if (w_grant_cpu || w_grant_aux) begin
                rom_a <= w_grant_aux ? aux_a : cpu_a;
            end
            r_s1_vld <= w_grant_cpu || w_grant_aux;
            r_s1_id  <= w_grant_aux;
            r_s2_vld <= r_s1_vld;
            r_s2_id  <= r_s1_id;

            // rom_q now holds the data for the stage-2 tag.
            if (r_s2_vld) begin
                if (r_s2_id) begin
                    aux_q      <= rom_q;
                    aux_ack    <= 1'b1;
                    r_aux_pend <= 1'b0;
                end else begin
                    cpu_q      <= rom_q;
                    cpu_ack    <= 1'b1;
                    r_cpu_pend <= 1'b0;
                end
            end

            if (w_grant_cpu) begin
                r_cpu_pend <= 1'b1;
            end
            if (w_grant_aux) begin
                r_aux_pend <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
//==============================================================================
// Module   : tb_rom_arbiter
// Purpose  : Self-checking bench for rom_arbiter with a behavioural ROM and
//            per-requester expected-data queues.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rom_arbiter;

    localparam int AW = 17;

    logic          clock;
    logic          reset;
    logic          cpu_req;
    logic [AW-1:0] cpu_a;
    logic          cpu_ack;
    logic [7:0]    cpu_q;
    logic          aux_req;
    logic [AW-1:0] aux_a;
    logic          aux_ack;
    logic [7:0]    aux_q;
    logic [AW-1:0] rom_a;
    logic [7:0]    rom_q;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] cpu_exp [$];
    logic [7:0] aux_exp [$];

    int n_checks = 0;
    int n_errors = 0;

    rom_arbiter #(.KB(128), .STARVE(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .cpu_req (cpu_req),
        .cpu_a   (cpu_a),
        .cpu_ack (cpu_ack),
        .cpu_q   (cpu_q),
        .aux_req (aux_req),
        .aux_a   (aux_a),
        .aux_ack (aux_ack),
        .aux_q   (aux_q),
        .rom_a   (rom_a),
        .rom_q   (rom_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) rom_q <= mem[rom_a];

    // Scoreboard: every ack pops the expected byte for that requester.
    always @(negedge clock) begin
        logic [7:0] exp_v;
        if (cpu_ack || aux_ack) begin
            n_checks++;
            if (cpu_ack && aux_ack) begin
                n_errors++;
                $display("FAIL dual_ack: cpu_ack=%b aux_ack=%b, required not both", cpu_ack, aux_ack);
            end
        end
        if (cpu_ack) begin
            n_checks++;
            if (cpu_exp.size() == 0) begin
                n_errors++;
                $display("FAIL cpu_unexpected_ack: cpu_q=%h with no read expected", cpu_q);
            end else begin
                exp_v = cpu_exp.pop_front();
                if (cpu_q !== exp_v) begin
                    n_errors++;
                    $display("FAIL cpu_data: got %h, expected %h", cpu_q, exp_v);
                end
            end
        end
        if (aux_ack) begin
            n_checks++;
            if (aux_exp.size() == 0) begin
                n_errors++;
                $display("FAIL aux_unexpected_ack: aux_q=%h with no read expected", aux_q);
            end else begin
                exp_v = aux_exp.pop_front();
                if (aux_q !== exp_v) begin
                    n_errors++;
                    $display("FAIL aux_data: got %h, expected %h", aux_q, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int t_ack = 0;
        mem[0]  = 8'hF3;
        cpu_a   = '0;
        cpu_req = 1'b1;
        reset   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (cpu_ack !== 1'b0 || aux_ack !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_ack: cpu_ack=%b aux_ack=%b, expected 0 0", cpu_ack, aux_ack);
            end
        end
        n_checks++;
        if (rom_a !== '0 || cpu_q !== 8'd0 || aux_q !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_values: rom_a=%h cpu_q=%h aux_q=%h, expected 0 0 0", rom_a, cpu_q, aux_q);
        end
        reset = 1'b0;
        cpu_exp.push_back(8'hF3);
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (cpu_ack && t_ack == 0) begin
                t_ack   = n;
                cpu_req = 1'b0;
            end
        end
        n_checks++;
        if (t_ack != 3) begin
            n_errors++;
            $display("FAIL reset_first_ack: ack at edge %0d, expected 3", t_ack);
        end
        n_checks++;
        if (cpu_exp.size() != 0 || aux_q !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_drain: cpu pending=%0d aux_q=%h, expected 0 00", cpu_exp.size(), aux_q);
        end
    endtask

    task automatic test_single_cpu();
        int acks = 0;
        int t1 = 0;
        int t2 = 0;
        mem[17'h01234] = 8'hA5;
        cpu_exp.push_back(8'hA5);
        cpu_exp.push_back(8'hA5);
        cpu_a   = 17'h01234;
        cpu_req = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 1) begin
                n_checks++;
                if (rom_a !== 17'h01234) begin
                    n_errors++;
                    $display("FAIL single_rom_a: rom_a=%h, expected 01234", rom_a);
                end
            end
            if (cpu_ack) begin
                acks++;
                if (acks == 1) t1 = n;
                if (acks == 2) begin
                    t2      = n;
                    cpu_req = 1'b0;
                end
            end
        end
        n_checks++;
        if (t1 != 3 || t2 != 6) begin
            n_errors++;
            $display("FAIL single_timing: acks at %0d,%0d, expected 3,6", t1, t2);
        end
        n_checks++;
        if (cpu_exp.size() != 0) begin
            n_errors++;
            $display("FAIL single_drain: %0d reads outstanding, expected 0", cpu_exp.size());
        end
    endtask

    task automatic test_contention();
        int tc = 0;
        int ta = 0;
        mem[17'h00001] = 8'hAF;
        mem[17'h1FFFF] = 8'h5C;
        cpu_exp.push_back(8'hAF);
        aux_exp.push_back(8'h5C);
        cpu_a   = 17'h00001;
        aux_a   = 17'h1FFFF;
        cpu_req = 1'b1;
        aux_req = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (cpu_ack && tc == 0) begin
                tc      = n;
                cpu_req = 1'b0;
            end
            if (aux_ack && ta == 0) begin
                ta      = n;
                aux_req = 1'b0;
            end
        end
        n_checks++;
        if (tc != 3 || ta != 4) begin
            n_errors++;
            $display("FAIL contention_timing: cpu ack %0d aux ack %0d, expected 3 4", tc, ta);
        end
        n_checks++;
        if (cpu_exp.size() != 0 || aux_exp.size() != 0) begin
            n_errors++;
            $display("FAIL contention_drain: cpu %0d aux %0d outstanding, expected 0 0", cpu_exp.size(), aux_exp.size());
        end
    endtask

    task automatic test_starvation();
        int ta = 0;
        int cc = 0;
        mem[17'h00200] = 8'h77;
        mem[17'h00ABC] = 8'h9E;
        for (int i = 0; i < 3; i++) cpu_exp.push_back(8'h77);
        aux_exp.push_back(8'h9E);
        cpu_a   = 17'h00200;
        aux_a   = 17'h00ABC;
        cpu_req = 1'b1;
        tick();
        aux_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (cpu_ack) begin
                cc++;
                if (cc == 3) cpu_req = 1'b0;
            end
            if (aux_ack && ta == 0) begin
                ta      = n;
                aux_req = 1'b0;
`ifndef ROMARB_ROUNDROBIN_EN
                n_checks++;
                if (dut.r_starve_cnt !== 4'd0) begin
                    n_errors++;
                    $display("FAIL starve_clear: starve_cnt=%0d, expected 0", dut.r_starve_cnt);
                end
`endif
            end
        end
        n_checks++;
        if (ta < 3 || ta > 7) begin
            n_errors++;
            $display("FAIL starve_bound: aux ack at %0d, expected within 3..7", ta);
        end
        n_checks++;
        if (cc != 3 || cpu_exp.size() != 0 || aux_exp.size() != 0) begin
            n_errors++;
            $display("FAIL starve_drain: cpu acks %0d, outstanding %0d/%0d, expected 3 0/0", cc, cpu_exp.size(), aux_exp.size());
        end
    endtask

    task automatic test_reset_midflight();
        int t_ack = 0;
        mem[17'h00042] = 8'h3C;
        cpu_a   = 17'h00042;
        cpu_req = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (cpu_ack !== 1'b0 || cpu_q !== 8'd0) begin
            n_errors++;
            $display("FAIL midflight_reset: cpu_ack=%b cpu_q=%h, expected 0 00", cpu_ack, cpu_q);
        end
        reset = 1'b0;
        cpu_exp.push_back(8'h3C);
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (cpu_ack && t_ack == 0) begin
                t_ack   = n;
                cpu_req = 1'b0;
            end
        end
        n_checks++;
        if (t_ack != 3 || cpu_exp.size() != 0) begin
            n_errors++;
            $display("FAIL midflight_regrant: ack at %0d outstanding %0d, expected 3 0", t_ack, cpu_exp.size());
        end
    endtask

`ifdef ROMARB_ROUNDROBIN_EN
    task automatic test_round_robin();
        int order [4];
        int cnt = 0;
        int nc = 0;
        int na = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mem[17'h00010] = 8'h11;
        mem[17'h00020] = 8'h22;
        for (int i = 0; i < 2; i++) begin
            cpu_exp.push_back(8'h11);
            aux_exp.push_back(8'h22);
        end
        cpu_a   = 17'h00010;
        aux_a   = 17'h00020;
        cpu_req = 1'b1;
        aux_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (cpu_ack && cnt < 4) begin
                order[cnt] = 0;
                cnt++;
                nc++;
                if (nc == 2) cpu_req = 1'b0;
            end
            if (aux_ack && cnt < 4) begin
                order[cnt] = 1;
                cnt++;
                na++;
                if (na == 2) aux_req = 1'b0;
            end
        end
        n_checks++;
        if (cnt != 4) begin
            n_errors++;
            $display("FAIL rr_count: %0d acks, expected 4", cnt);
        end
        for (int i = 0; i < cnt; i++) begin
            n_checks++;
            if (order[i] != (i % 2)) begin
                n_errors++;
                $display("FAIL rr_order: ack %0d from %0d, expected %0d", i, order[i], i % 2);
            end
        end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        cpu_req = 1'b0;
        aux_req = 1'b0;
        cpu_a   = '0;
        aux_a   = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 7 + 3);

        test_reset();
        test_single_cpu();
        test_contention();
        test_starvation();
        test_reset_midflight();
`ifdef ROMARB_ROUNDROBIN_EN
        test_round_robin();
`endif
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
